// File: rtl/program_sequencer.sv
// Program sequencer: feeds a stored word stream to a processor, one instruction per Run/Done handshake.
// Latency: Run one edge after Start/Done; the processor throttles via Done, a stall of TIMEOUT cycles parks in ERR.
module program_sequencer #(
  parameter int         DEPTH   = 32,
  parameter logic [2:0] MVI_OP  = 3'b001,
  parameter int         TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        Resetn,
  input  logic        Start,
  input  logic        LoadEn,
  input  logic [4:0]  LoadAddr,
  input  logic [15:0] LoadData,
  input  logic [5:0]  Length,
  input  logic        Done,
  output logic        Run,
  output logic [15:0] DIN,
  output logic [4:0]  PC,
  output logic        Busy,
  output logic        Finished,
  output logic        Error
);

  localparam int         CW      = $clog2(TIMEOUT + 1);
  localparam logic [5:0] DEPTH_W = 6'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} state_t;

  state_t          state, state_nxt;
  logic [15:0]     mem [DEPTH];
  logic [4:0]      pc_nxt;
  logic [15:0]     din_nxt;
  logic [5:0]      len, len_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            fin_nxt;
  logic [5:0]      pc_inc;
  logic [4:0]      pc_plus1;

  // pc_inc is PC+1 at Len's width so the last-word test cannot wrap
  assign pc_inc   = {1'b0, PC} + 6'd1;
  assign pc_plus1 = PC + 5'd1;

  assign Run   = (state == ISSUE);
  assign Busy  = (state == ISSUE) || (state == WAIT);
  assign Error = (state == ERR);

  always_ff @(posedge clk) begin
    if (Resetn && LoadEn && !Busy) begin
      mem[LoadAddr] <= LoadData;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = PC;
    din_nxt   = DIN;
    len_nxt   = len;
    cnt_nxt   = cnt;
    fin_nxt   = 1'b0;
    case (state)
      IDLE, ERR: begin
        if (Start) begin
          if (Length == 6'd0) begin
            fin_nxt = 1'b1;
          end else begin
            state_nxt = ISSUE;
            pc_nxt    = 5'd0;
            din_nxt   = mem[0];
            len_nxt   = (Length > DEPTH_W) ? DEPTH_W : Length;
          end
        end
      end
      ISSUE: begin
        cnt_nxt = '0;
        if (DIN[15:13] == MVI_OP) begin
          // two-word instruction: the immediate must still lie inside the program
          if (pc_inc == len) begin
            state_nxt = ERR;
          end else begin
            state_nxt = WAIT;
            pc_nxt    = pc_plus1;
            din_nxt   = mem[pc_plus1];
          end
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (Done) begin
          if (pc_inc == len) begin
            state_nxt = IDLE;
            fin_nxt   = 1'b1;
          end else begin
            state_nxt = ISSUE;
            pc_nxt    = pc_plus1;
            din_nxt   = mem[pc_plus1];
          end
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_nxt = ERR;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Resetn) begin
      state    <= IDLE;
      PC       <= '0;
      DIN      <= '0;
      len      <= '0;
      cnt      <= '0;
      Finished <= 1'b0;
    end else begin
      state    <= state_nxt;
      PC       <= pc_nxt;
      DIN      <= din_nxt;
      len      <= len_nxt;
      cnt      <= cnt_nxt;
      Finished <= fin_nxt;
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: random programs walked by a word-list model, random Done delays,
// stray Start/LoadEn while busy, plus directed MVI, timeout, zero-length and reset cases.
module tb_program_sequencer;

  localparam int         DEPTH = 32;
  localparam logic [2:0] MVI   = 3'b001;
  localparam int         TO    = 16;

  logic        clk = 1'b0;
  logic        Resetn, Start, LoadEn, Done;
  logic [4:0]  LoadAddr;
  logic [15:0] LoadData;
  logic [5:0]  Length;
  logic        Run, Busy, Finished, Error;
  logic [15:0] DIN;
  logic [4:0]  PC;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] mm [DEPTH];
  logic [15:0] last_din;

  always #5 clk = ~clk;

  program_sequencer #(.DEPTH(DEPTH), .MVI_OP(MVI), .TIMEOUT(TO)) dut (
    .clk(clk), .Resetn(Resetn), .Start(Start), .LoadEn(LoadEn),
    .LoadAddr(LoadAddr), .LoadData(LoadData), .Length(Length), .Done(Done),
    .Run(Run), .DIN(DIN), .PC(PC), .Busy(Busy), .Finished(Finished), .Error(Error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  task automatic load(input int a, input logic [15:0] d);
    LoadEn = 1'b1; LoadAddr = a[4:0]; LoadData = d;
    step;
    LoadEn = 1'b0;
    mm[a] = d;
  endtask

  task automatic chk_parked(input string tag, input logic err);
    chk({tag, ".run"}, Run, 0);
    chk({tag, ".busy"}, Busy, 0);
    chk({tag, ".err"}, Error, err);
    chk({tag, ".din"}, DIN, last_din);
  endtask

  // Walk the program as a list of words: each entry is one instruction,
  // an MVI entry swallows the following word as its immediate.
  task automatic run_prog(input int length, input int dmin, input int dmax);
    int L, i, d;
    logic [15:0] w;
    L = (length > DEPTH) ? DEPTH : length;
    Length = length[5:0]; Start = 1'b1;
    step;
    Start = 1'b0; Length = 6'($urandom);
    if (L == 0) begin
      chk("len0.fin", Finished, 1);
      chk("len0.busy", Busy, 0);
      step;
      chk("len0.fin_pulse", Finished, 0);
      return;
    end
    i = 0;
    forever begin
      chk("issue.run", Run, 1);
      chk("issue.din", DIN, mm[i]);
      chk("issue.pc", PC, i);
      chk("issue.busy", Busy, 1);
      chk("issue.err", Error, 0);
      w = mm[i];
      Done = 1'($urandom);
      step;
      Done = 1'b0;
      chk("post_issue.run", Run, 0);
      if (w[15:13] == MVI && i == L - 1) begin
        last_din = w;
        chk("mvi_end.err", Error, 1);
        repeat (3) begin
          step;
          chk_parked("mvi_end", 1'b1);
        end
        return;
      end
      if (w[15:13] == MVI) begin
        i++;
        chk("imm.din", DIN, mm[i]);
        chk("imm.pc", PC, i);
      end
      chk("wait.busy", Busy, 1);
      d = $urandom_range(dmax, dmin);
      repeat (d) begin
        Start = 1'($urandom); LoadEn = 1'($urandom);
        LoadAddr = 5'($urandom); LoadData = 16'($urandom);
        step;
        chk("wait.run", Run, 0);
        chk("wait.busy", Busy, 1);
        chk("wait.din", DIN, mm[i]);
      end
      Start = 1'b0; LoadEn = 1'b0; Done = 1'b1;
      step;
      Done = 1'b0;
      if (i + 1 == L) begin
        last_din = mm[i];
        chk("end.fin", Finished, 1);
        chk_parked("end", 1'b0);
        step;
        chk("end.fin_pulse", Finished, 0);
        chk("end.din_hold", DIN, last_din);
        return;
      end
      i++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Resetn = 1'b0; Start = 1'b0; LoadEn = 1'b0; LoadAddr = '0;
    LoadData = '0; Length = '0; Done = 1'b0;
    step; step;
    last_din = 16'h0000;
    chk("rst.pc", PC, 0);
    chk("rst.fin", Finished, 0);
    chk_parked("rst", 1'b0);
    Resetn = 1'b1;
    for (int k = 0; k < DEPTH; k++) load(k, 16'($urandom));

    load(0, 16'h2050); load(1, 16'h4123); load(2, 16'h6007);
    run_prog(3, 1, 1);

    load(0, 16'h3000); load(1, 16'h00A5);
    run_prog(2, 0, 3);

    load(0, 16'h3000);
    run_prog(1, 0, 2);
    run_prog(0, 0, 0);
    chk("len0_in_err.err", Error, 1);

    // Timeout: WAIT entered, Done withheld for TO cycles
    load(0, 16'h4444);
    Length = 6'd1; Start = 1'b1;
    step;
    Start = 1'b0;
    chk("to.run", Run, 1);
    step;
    repeat (TO - 1) begin
      step;
      chk("to.busy", Busy, 1);
      chk("to.err_early", Error, 0);
    end
    step;
    last_din = 16'h4444;
    chk("to.err", Error, 1);
    chk_parked("to", 1'b1);
    run_prog(1, 0, 2);

    // Reset mid-WAIT, with competing Start/LoadEn/Done
    load(0, 16'h4001); load(1, 16'h5002); load(2, 16'h6003);
    Length = 6'd3; Start = 1'b1;
    step;
    Start = 1'b0;
    step;
    LoadEn = 1'b1; LoadAddr = 5'd0; LoadData = 16'hFFFF;
    step;
    chk("busy_load.din", DIN, 16'h4001);
    Resetn = 1'b0; Start = 1'b1; Done = 1'b1;
    step;
    Resetn = 1'b1; Start = 1'b0; Done = 1'b0; LoadEn = 1'b0;
    last_din = 16'h0000;
    chk("rst_wait.pc", PC, 0);
    chk("rst_wait.fin", Finished, 0);
    chk_parked("rst_wait", 1'b0);
    step;
    chk_parked("rst_wait_hold", 1'b0);
    run_prog(3, 0, 2);

    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 4; k++) load(int'($urandom_range(DEPTH - 1, 0)), 16'($urandom));
      if (r % 5 == 4) run_prog(0, 0, 0);
      else run_prog(int'($urandom_range(63, 1)), 0, TO - 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
